// File: rtl/alu_exec_unit.sv
// EX-stage ALU: LEGv8 ALU_Op/opcode decode plus a registered execute stage with
// iterative MUL/UDIV, NZCV flags and a valid/ready handshake on both sides.
module alu_exec_unit #(
  parameter int WIDTH  = 64,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALU_Op,
  input  logic [10:0]      ALU_INSTRUCTION,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL, OP_DIV, OP_LSL, OP_LSR, OP_PASSB, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             ill_q, ill_d, dbz_q, dbz_d;

  op_t dec_op;

  always_comb begin
    dec_op = OP_ILL;
    case (ALU_Op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_PASSB;
      2'b10: begin
        case (ALU_INSTRUCTION)
          11'b10001011000: dec_op = OP_ADD;
          11'b11001011000: dec_op = OP_SUB;
          11'b10001010000: dec_op = OP_AND;
          11'b10101010000: dec_op = OP_ORR;
          11'b10011011000: dec_op = OP_MUL;
          11'b10011010110: if (DIV_EN) dec_op = OP_DIV;
          11'b11010011011: dec_op = OP_LSL;
          11'b11010011010: dec_op = OP_LSR;
          default:         dec_op = OP_ILL;
        endcase
      end
      default: dec_op = OP_ILL;
    endcase
  end

  // SUB reuses the adder as A + ~B + 1 so carry means "no borrow"
  logic             is_sub;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum;

  always_comb begin
    is_sub = (dec_op == OP_SUB);
    b_add  = is_sub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
  end

  logic             wr;
  logic [WIDTH-1:0] fin;
  logic             fin_c, fin_v, fin_ill, fin_dbz;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh, trial;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    ill_d    = ill_q;
    dbz_d    = dbz_q;
    wr       = 1'b0;
    fin      = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    fin_ill  = 1'b0;
    fin_dbz  = 1'b0;
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    rem_sh   = {acc_q, a_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          acc_d = '0;
          cnt_d = '0;
          case (dec_op)
            OP_MUL: state_d = S_MUL;
            OP_DIV: begin
              if (B == '0) begin
                wr      = 1'b1;
                fin_dbz = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_DIV;
              end
            end
            default: begin
              wr      = 1'b1;
              state_d = S_DONE;
              case (dec_op)
                OP_ADD, OP_SUB: begin
                  fin   = sum[WIDTH-1:0];
                  fin_c = sum[WIDTH];
                  fin_v = (A[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                end
                OP_AND:   fin = A & B;
                OP_ORR:   fin = A | B;
                OP_LSL:   fin = A << B[SHW-1:0];
                OP_LSR:   fin = A >> B[SHW-1:0];
                OP_PASSB: fin = B;
                default:  fin_ill = 1'b1;
              endcase
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_ITER) begin
          wr      = 1'b1;
          fin     = mul_acc;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        // a_q shifts the dividend out at the top and the quotient in at the bottom
        a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
        acc_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_ITER) begin
          wr      = 1'b1;
          fin     = {a_q[WIDTH-2:0], ~trial[WIDTH]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      result_d = fin;
      n_d      = fin[WIDTH-1];
      z_d      = (fin == '0);
      c_d      = fin_c;
      v_d      = fin_v;
      ill_d    = fin_ill;
      dbz_d    = fin_dbz;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      ill_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      ill_q    <= ill_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign flag_n      = n_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign flag_v      = v_q;
  assign illegal     = ill_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit at WIDTH=8: directed cases, randomized
// transactions against an arithmetic reference model, and a DIV_EN=0 instance.
module tb_alu_exec_unit;

   localparam int W = 8;

   localparam logic [10:0] I_ADD  = 11'b10001011000;
   localparam logic [10:0] I_SUB  = 11'b11001011000;
   localparam logic [10:0] I_AND  = 11'b10001010000;
   localparam logic [10:0] I_ORR  = 11'b10101010000;
   localparam logic [10:0] I_MUL  = 11'b10011011000;
   localparam logic [10:0] I_UDIV = 11'b10011010110;
   localparam logic [10:0] I_LSL  = 11'b11010011011;
   localparam logic [10:0] I_LSR  = 11'b11010011010;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_valid_nd, out_ready;
   logic [1:0]    alu_op;
   logic [10:0]   alu_instr;
   logic [W-1:0]  a, b;

   logic          in_ready, out_valid, flag_n, flag_z, flag_c, flag_v, illegal, div_by_zero;
   logic [W-1:0]  result;
   logic          in_ready_nd, out_valid_nd, flag_n_nd, flag_z_nd, flag_c_nd, flag_v_nd;
   logic          illegal_nd, div_by_zero_nd;
   logic [W-1:0]  result_nd;

   int errors = 0;
   int checks = 0;

   alu_exec_unit #(.WIDTH(W), .DIV_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_Op(alu_op), .ALU_INSTRUCTION(alu_instr), .A(a), .B(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .illegal(illegal), .div_by_zero(div_by_zero)
   );

   alu_exec_unit #(.WIDTH(W), .DIV_EN(1'b0)) dut_nd (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid_nd), .in_ready(in_ready_nd),
      .ALU_Op(alu_op), .ALU_INSTRUCTION(alu_instr), .A(a), .B(b),
      .out_valid(out_valid_nd), .out_ready(1'b1), .result(result_nd),
      .flag_n(flag_n_nd), .flag_z(flag_z_nd), .flag_c(flag_c_nd), .flag_v(flag_v_nd),
      .illegal(illegal_nd), .div_by_zero(div_by_zero_nd)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so a stuck handshake can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model computed from the instruction semantics with plain integer arithmetic
   task automatic modelOp(input logic [1:0] op, input logic [10:0] ins, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output logic [W-1:0] res, output logic [3:0] fl,
                          output logic ill, output logic dbz, output int lat);
      int ia, ib, sa, sb, s, sv;
      logic c, v;
      ia = int'(av);
      ib = int'(bv);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      res = '0; c = 1'b0; v = 1'b0; ill = 1'b0; dbz = 1'b0; lat = 1;
      if (op == 2'b01) begin
         res = bv;
      end else if (op == 2'b11) begin
         ill = 1'b1;
      end else if (op == 2'b00 || ins == I_ADD) begin
         s = ia + ib;  res = W'(s);  c = (s > 255);
         sv = sa + sb; v = (sv > 127) || (sv < -128);
      end else if (ins == I_SUB) begin
         s = ia - ib;  res = W'(s);  c = (ia >= ib);
         sv = sa - sb; v = (sv > 127) || (sv < -128);
      end else if (ins == I_AND) begin
         res = av & bv;
      end else if (ins == I_ORR) begin
         res = av | bv;
      end else if (ins == I_MUL) begin
         res = W'((ia * ib) % 256);
         lat = W + 1;
      end else if (ins == I_UDIV) begin
         if (ib == 0) dbz = 1'b1;
         else begin
            res = W'(ia / ib);
            lat = W + 1;
         end
      end else if (ins == I_LSL) begin
         res = W'((ia * (1 << (ib % W))) % 256);
      end else if (ins == I_LSR) begin
         res = W'(ia / (1 << (ib % W)));
      end else begin
         ill = 1'b1;
      end
      fl = {res[W-1], (res == '0), c, v};
   endtask

   // Waits for in_ready, issues one request, scrambles inputs, then measures cycles to out_valid
   task automatic applyStimulus(input logic [1:0] op, input logic [10:0] ins, input logic [W-1:0] av,
                                input logic [W-1:0] bv, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      alu_op = op; alu_instr = ins; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); alu_instr = 11'($urandom); alu_op = 2'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic checkTxn(input string tag, input logic [1:0] op, input logic [10:0] ins,
                           input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] expRes,
                           input logic [3:0] expFl, input logic expIll, input logic expDbz, input int expLat);
      int lat;
      applyStimulus(op, ins, av, bv, lat);
      checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
      checkOutput({tag, ".nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(expFl));
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'(expIll));
      checkOutput({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(expDbz));
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // Directed test-plan cases, then randomized traffic against the model
   initial begin
      logic [W-1:0] mRes;
      logic [3:0]   mFl;
      logic         mIll, mDbz;
      int           mLat;
      logic [1:0]   rOp;
      logic [10:0]  rIns;
      logic [W-1:0] rA, rB;
      logic [10:0]  legal [8];

      legal = '{I_ADD, I_SUB, I_AND, I_ORR, I_MUL, I_UDIV, I_LSL, I_LSR};
      reset_n = 1'b0; in_valid = 1'b0; in_valid_nd = 1'b0; out_ready = 1'b0;
      alu_op = 2'b00; alu_instr = '0; a = '0; b = '0;
      #12;
      checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset.result", 32'(result), 32'd0);
      checkOutput("reset.flags", 32'({flag_n, flag_z, flag_c, flag_v, illegal, div_by_zero}), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // DIV_EN=0 instance: UDIV must decode as illegal with single-cycle latency
      alu_op = 2'b10; alu_instr = I_UDIV; a = 8'd200; b = 8'd7; in_valid_nd = 1'b1;
      @(posedge clk); #1;
      in_valid_nd = 1'b0;
      checkOutput("nodiv.out_valid", 32'(out_valid_nd), 32'd1);
      checkOutput("nodiv.illegal", 32'(illegal_nd), 32'd1);
      checkOutput("nodiv.result", 32'(result_nd), 32'd0);
      checkOutput("nodiv.div_by_zero", 32'(div_by_zero_nd), 32'd0);
      @(posedge clk); #1;

      checkTxn("sub_eq",   2'b10, I_SUB, 8'h05, 8'h05, 8'h00, 4'b0110, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("sub_ovf",  2'b10, I_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("add_wrap", 2'b10, I_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("ldst_add", 2'b00, 11'h000, 8'h10, 8'h04, 8'h14, 4'b0000, 1'b0, 1'b0, 1);
      releaseResult();

      checkTxn("mul", 2'b10, I_MUL, 8'd13, 8'd11, 8'h8F, 4'b1000, 1'b0, 1'b0, W + 1);
      out_ready = 1'b0; alu_op = 2'b00; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("hold.out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold.result", 32'(result), 32'h8F);
         checkOutput("hold.in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      releaseResult();
      checkOutput("hold.exit_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("hold.not_queued", 32'(out_valid), 32'd0);
      checkOutput("hold.result_kept", 32'(result), 32'h8F);

      checkTxn("udiv",     2'b10, I_UDIV, 8'd200, 8'd7, 8'd28, 4'b0000, 1'b0, 1'b0, W + 1);
      releaseResult();
      checkTxn("udiv_b0",  2'b10, I_UDIV, 8'd200, 8'd0, 8'd0, 4'b0100, 1'b0, 1'b1, 1);
      releaseResult();
      checkTxn("lsl",      2'b10, I_LSL, 8'h81, 8'h0A, 8'h04, 4'b0000, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("lsr",      2'b10, I_LSR, 8'h81, 8'h03, 8'h10, 4'b0000, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("bad_opc",  2'b10, 11'b11111111111, 8'h12, 8'h34, 8'h00, 4'b0100, 1'b1, 1'b0, 1);
      releaseResult();
      checkTxn("cbz_pass", 2'b01, 11'h000, 8'h33, 8'h00, 8'h00, 4'b0100, 1'b0, 1'b0, 1);
      releaseResult();
      checkTxn("aluop_11", 2'b11, I_ADD, 8'h05, 8'h06, 8'h00, 4'b0100, 1'b1, 1'b0, 1);
      releaseResult();
      checkTxn("pass_b",   2'b01, 11'h000, 8'h00, 8'hC3, 8'hC3, 4'b1000, 1'b0, 1'b0, 1);
      releaseResult();

      // Reset in the middle of a multiply discards it and clears every output at once
      alu_op = 2'b10; alu_instr = I_MUL; a = 8'd13; b = 8'd11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset.result", 32'(result), 32'd0);
      checkOutput("midreset.flags", 32'({flag_n, flag_z, flag_c, flag_v, illegal, div_by_zero}), 32'd0);
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset.idle", 32'(out_valid), 32'd0);
      checkTxn("post_reset_add", 2'b10, I_ADD, 8'h70, 8'h20, 8'h90, 4'b1001, 1'b0, 1'b0, 1);
      releaseResult();

      for (int t = 0; t < 40; t++) begin
         int r;
         r = int'($urandom_range(0, 11));
         rOp = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
         rIns = ($urandom_range(0, 7) == 0) ? 11'($urandom) : legal[$urandom_range(0, 7)];
         rA = W'($urandom);
         rB = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
         modelOp(rOp, rIns, rA, rB, mRes, mFl, mIll, mDbz, mLat);
         checkTxn($sformatf("rand%0d", t), rOp, rIns, rA, rB, mRes, mFl, mIll, mDbz, mLat);
         releaseResult();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
